pool_window_gen: RTL and testbench

Streaming front end for the 2x2 max-pooling stage. Accepts a feature map one pixel per handshake in raster order (row-major, top-left first). Buffers one row and presents each non-overlapping 2x2 window on four parallel outputs, which feed the `max` unit's n1..n4 inputs directly. Sits between the convolution/activation output stream and `max`.

---
 rtl/pool_window_gen.sv | 88 ++++++++
 tb/tb_pool_window_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// 2x2 non-overlapping window generator for max pooling: buffers one row, emits (n1..n4) per window.
// Optional POOL_WIN_LAST_EN adds out_last, flagging the final window of each frame.
module pool_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] n1,
  output logic [DATA_WIDTH-1:0] n2,
  output logic [DATA_WIDTH-1:0] n3,
  output logic [DATA_WIDTH-1:0] n4
`ifdef POOL_WIN_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col_prev;
  logic [DATA_WIDTH-1:0] held;
  logic [DATA_WIDTH-1:0] linebuf [IMG_W];
  logic                  accept;
  logic                  col_last;
  logic                  row_last;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  // A window only forms at odd col, so col-1 never underflows.
  assign col_prev = col - CW'(1);

  always_ff @(posedge clk) begin
    if (accept && !row[0]) linebuf[col] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      held      <= '0;
      n1        <= '0;
      n2        <= '0;
      n3        <= '0;
      n4        <= '0;
`ifdef POOL_WIN_LAST_EN
      out_last  <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (row[0]) begin
          if (!col[0]) begin
            held <= in_data;
          end else begin
            n1        <= linebuf[col_prev];
            n2        <= linebuf[col];
            n3        <= held;
            n4        <= in_data;
            out_valid <= 1'b1;
`ifdef POOL_WIN_LAST_EN
            out_last  <= row_last && col_last;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Randomised and directed bench for pool_window_gen against a frame-array reference model.
module tb_pool_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] n1, n2, n3, n4;
  logic        out_last;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_ovalid;
  logic [15:0] s_n1, s_n2, s_n3, s_n4;
  logic        s_last;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pool_window_gen #(.DATA_WIDTH(16), .IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .n1(n1), .n2(n2), .n3(n3), .n4(n4)
`ifdef POOL_WIN_LAST_EN
    , .out_last(out_last)
`endif
  );

  pool_window_gen #(.DATA_WIDTH(16), .IMG_W(2), .IMG_H(2)) u_small (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data),
    .out_valid(s_ovalid), .out_ready(1'b1), .n1(s_n1), .n2(s_n2), .n3(s_n3), .n4(s_n4)
`ifdef POOL_WIN_LAST_EN
    , .out_last(s_last)
`endif
  );

`ifndef POOL_WIN_LAST_EN
  assign out_last = 1'b0;
  assign s_last   = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the whole current frame and picks window pixels by index.
  typedef struct packed {
    logic [15:0] a, b, c, d;
    logic        last;
  } win_t;

  logic [15:0] pix [NP];
  int          k;
  logic        exp_valid;
  win_t        exp_w;
  win_t        log_q [$];

  always @(posedge clk or posedge reset) begin
    logic acc;
    int   r, c;
    if (reset) begin
      k = 0;
      exp_valid = 1'b0;
      exp_w = '0;
    end else begin
      acc = in_valid && (!exp_valid || out_ready);
      if (exp_valid && out_ready) exp_valid = 1'b0;
      if (acc) begin
        pix[k] = in_data;
        r = k / W;
        c = k % W;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          exp_w.a = pix[k - W - 1];
          exp_w.b = pix[k - W];
          exp_w.c = pix[k - 1];
          exp_w.d = in_data;
          exp_w.last = (k == NP - 1);
          exp_valid = 1'b1;
          log_q.push_back(exp_w);
        end
        k = (k + 1) % NP;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", {31'b0, in_ready}, {31'b0, !exp_valid || out_ready});
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    check("n1", {16'b0, n1}, {16'b0, exp_w.a});
    check("n2", {16'b0, n2}, {16'b0, exp_w.b});
    check("n3", {16'b0, n3}, {16'b0, exp_w.c});
    check("n4", {16'b0, n4}, {16'b0, exp_w.d});
`ifdef POOL_WIN_LAST_EN
    check("out_last", {31'b0, out_last}, {31'b0, exp_w.last});
`endif
  end

  // out_ready: 0 = always ready, 1 = random, 2 = stall for stall_left window-cycles then ready
  int rdy_mode = 0;
  int stall_left = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: if (stall_left > 0 && out_valid) begin
             out_ready = 1'b0;
             stall_left--;
           end else begin
             out_ready = 1'b1;
           end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send_px(input logic [15:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [15:0] base, input bit gaps);
    for (int i = 0; i < NP; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_px(gaps ? 16'($urandom) : base + 16'(i));
    end
  endtask

  task automatic chk_win(input string name, input int idx, input logic [15:0] a, b, c, d, input bit last);
    win_t w;
    if (idx >= log_q.size()) begin
      check({name, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      w = log_q[idx];
      check(name, {w.a, w.b}, {a, b});
      check(name, {w.c, w.d}, {c, d});
      check({name, "_last"}, {31'b0, w.last}, {31'b0, last});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] sp [4];
    logic [15:0] mx;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_n1", {16'b0, n1}, 32'd0);
    check("reset_out_last", {31'b0, out_last}, 32'd0);
    @(posedge clk);
    #1;

    log_q.delete();
    send_frame(16'h0000, 1'b0);
    idle(3);
    check("t1_count", 32'(log_q.size()), 32'd4);
    chk_win("t1_w0", 0, 16'h0, 16'h1, 16'h4, 16'h5, 1'b0);
    chk_win("t1_w1", 1, 16'h2, 16'h3, 16'h6, 16'h7, 1'b0);
    chk_win("t1_w2", 2, 16'h8, 16'h9, 16'hC, 16'hD, 1'b0);
    chk_win("t1_w3", 3, 16'hA, 16'hB, 16'hE, 16'hF, 1'b1);

    log_q.delete();
    stall_left = 5;
    rdy_mode = 2;
    send_frame(16'h0000, 1'b0);
    idle(3);
    rdy_mode = 0;
    check("t2_count", 32'(log_q.size()), 32'd4);
    chk_win("t2_w0", 0, 16'h0, 16'h1, 16'h4, 16'h5, 1'b0);
    chk_win("t2_w3", 3, 16'hA, 16'hB, 16'hE, 16'hF, 1'b1);

    log_q.delete();
    send_frame(16'h0000, 1'b0);
    send_frame(16'h0100, 1'b0);
    idle(3);
    check("t3_count", 32'(log_q.size()), 32'd8);
    chk_win("t3_w4", 4, 16'h100, 16'h101, 16'h104, 16'h105, 1'b0);

    for (int i = 0; i < 7; i++) send_px(16'(i));
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    log_q.delete();
    send_frame(16'h0200, 1'b0);
    idle(3);
    check("t4_count", 32'(log_q.size()), 32'd4);
    chk_win("t4_w0", 0, 16'h200, 16'h201, 16'h204, 16'h205, 1'b0);

    rdy_mode = 1;
    for (int f = 0; f < 6; f++) send_frame(16'h0, 1'b1);
    rdy_mode = 0;
    idle(4);

    sp[0] = 16'h1000; sp[1] = 16'hCCCC; sp[2] = 16'hCCCC; sp[3] = 16'h3000;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = sp[i];
      @(posedge clk);
      #1;
      if (i == 2) check("small_latency", {31'b0, s_ovalid}, 32'd0);
    end
    s_valid = 1'b0;
    check("small_valid", {31'b0, s_ovalid}, 32'd1);
    check("small_n12", {s_n1, s_n2}, {16'h1000, 16'hCCCC});
    check("small_n34", {s_n3, s_n4}, {16'hCCCC, 16'h3000});
`ifdef POOL_WIN_LAST_EN
    check("small_last", {31'b0, s_last}, 32'd1);
`endif
    mx = s_n1;
    if (s_n2 > mx) mx = s_n2;
    if (s_n3 > mx) mx = s_n3;
    if (s_n4 > mx) mx = s_n4;
    check("small_max", {16'b0, mx}, 32'h0000CCCC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, failed=%0d", fails + 1);
    $fatal(1, "timeout");
  end

endmodule
